// File: rtl/sfif_tx_buf.sv
// TLP store-and-replay buffer feeding the PCIe core TX port.
// Loader-written TLPs are kept after reading, so rprst can replay the whole sequence.
module sfif_tx_buf #(
  parameter int AW  = 9,
  parameter int CAW = 5
) (
  input  logic        clk_125,
  input  logic        rst,
  input  logic        wr_clr,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  input  logic        wr_sop,
  input  logic        wr_eop,
  input  logic [11:0] wr_cr,
  output logic        wr_ovf,
  input  logic        rprst,
  input  logic        tx_cr_read,
  input  logic        tx_d_read,
  input  logic        tx_rdy,
  input  logic [7:0]  ph_cr,
  input  logic [11:0] pd_cr,
  input  logic [7:0]  nph_cr,
  input  logic [11:0] npd_cr,
  output logic        credit_available,
  output logic        tx_empty,
  output logic        tx_val,
  output logic        tx_st,
  output logic        tx_end,
  output logic [63:0] tx_data
);
  localparam int DDEPTH = 2**AW;
  localparam int CDEPTH = 2**CAW;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [63:0] data;
  } word_t;

  word_t       r_dmem [DDEPTH];
  logic [11:0] r_cmem [CDEPTH];

  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic [CAW:0] r_cwr_ptr, r_crd_ptr;
  logic         r_pending;
  logic [1:0]   r_need_type;
  logic [9:0]   r_need_data;
  logic         r_wr_ovf, r_cav;
  logic         r_tx_val, r_tx_st, r_tx_end;
  logic [63:0]  r_tx_data;

  logic  w_dfull, w_cfull, w_empty, w_pop, w_dwr, w_cwr, w_cr_hit, w_fit;
  word_t w_rd_word;

  // Pointers never wrap and stop at the store depth, so the MSB alone marks "full".
  assign w_dfull   = r_wr_ptr[AW];
  assign w_cfull   = r_cwr_ptr[CAW];
  assign w_empty   = (r_rd_ptr == r_wr_ptr);
  assign w_dwr     = wr_en & ~wr_clr & ~w_dfull;
  assign w_cwr     = wr_en & wr_eop & ~wr_clr & ~w_cfull;
  assign w_pop     = tx_d_read & tx_rdy & ~w_empty & ~rprst & ~wr_clr;
  assign w_rd_word = r_dmem[r_rd_ptr[AW-1:0]];
  assign w_cr_hit  = (r_crd_ptr != r_cwr_ptr);

  always_comb begin
    w_fit = 1'b1;
    case (r_need_type)
      2'd0:    w_fit = (ph_cr  != 8'd0) && (pd_cr  >= {2'b00, r_need_data});
      2'd1:    w_fit = (nph_cr != 8'd0) && (npd_cr >= {2'b00, r_need_data});
      default: w_fit = 1'b1;
    endcase
  end

  // Store arrays carry no reset; only the pointers define what is valid.
  always_ff @(posedge clk_125) begin
    if (w_dwr) r_dmem[r_wr_ptr[AW-1:0]] <= '{sop: wr_sop, eop: wr_eop, data: wr_data};
    if (w_cwr) r_cmem[r_cwr_ptr[CAW-1:0]] <= wr_cr;
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cwr_ptr   <= '0;
      r_crd_ptr   <= '0;
      r_pending   <= 1'b0;
      r_need_type <= 2'd0;
      r_need_data <= 10'd0;
      r_wr_ovf    <= 1'b0;
      r_cav       <= 1'b0;
      r_tx_val    <= 1'b0;
      r_tx_st     <= 1'b0;
      r_tx_end    <= 1'b0;
      r_tx_data   <= 64'd0;
    end else if (wr_clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cwr_ptr <= '0;
      r_crd_ptr <= '0;
      r_pending <= 1'b0;
      r_wr_ovf  <= 1'b0;
      r_cav     <= 1'b0;
      r_tx_val  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (w_dfull) r_wr_ovf <= 1'b1;
        else         r_wr_ptr <= r_wr_ptr + 1'b1;
        if (wr_eop) begin
          if (w_cfull) r_wr_ovf  <= 1'b1;
          else         r_cwr_ptr <= r_cwr_ptr + 1'b1;
        end
      end

      if (rprst) begin
        r_rd_ptr  <= '0;
        r_crd_ptr <= '0;
        r_pending <= 1'b0;
        r_cav     <= 1'b0;
        r_tx_val  <= 1'b0;
      end else begin
        r_tx_val <= w_pop;
        if (r_pending) r_cav <= w_fit;
        if (w_pop) begin
          r_tx_data <= w_rd_word.data;
          r_tx_st   <= w_rd_word.sop;
          r_tx_end  <= w_rd_word.eop;
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          if (w_rd_word.sop) begin
            r_pending <= 1'b0;
            r_cav     <= 1'b0;
          end
        end
        // A new lookup takes precedence over the start-of-TLP release in the same cycle.
        if (tx_cr_read) begin
          if (w_cr_hit) begin
            {r_need_type, r_need_data} <= r_cmem[r_crd_ptr[CAW-1:0]];
            r_crd_ptr <= r_crd_ptr + 1'b1;
          end else begin
            r_need_type <= 2'd3;
            r_need_data <= 10'd0;
          end
          r_pending <= 1'b1;
          r_cav     <= 1'b0;
        end
      end
    end
  end

  assign wr_ovf           = r_wr_ovf;
  assign credit_available = r_cav;
  assign tx_empty         = w_empty;
  assign tx_val           = r_tx_val;
  assign tx_st            = r_tx_st;
  assign tx_end           = r_tx_end;
  assign tx_data          = r_tx_data;

endmodule

// File: tb/tb_sfif_tx_buf.sv
// Self-checking bench for sfif_tx_buf: directed replay scenarios plus random traffic
// compared every cycle against a counter/array model of the buffer.
module tb_sfif_tx_buf;
  localparam int AW  = 4;
  localparam int CAW = 3;
  localparam int DD  = 2**AW;
  localparam int CD  = 2**CAW;

  logic        clk_125 = 1'b0;
  logic        rst, wr_clr, wr_en, wr_sop, wr_eop, rprst, tx_cr_read, tx_d_read, tx_rdy;
  logic [63:0] wr_data;
  logic [11:0] wr_cr, pd_cr, npd_cr;
  logic [7:0]  ph_cr, nph_cr;
  logic        wr_ovf, credit_available, tx_empty, tx_val, tx_st, tx_end;
  logic [63:0] tx_data;

  sfif_tx_buf #(.AW(AW), .CAW(CAW)) dut (
    .clk_125(clk_125), .rst(rst), .wr_clr(wr_clr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_cr(wr_cr), .wr_ovf(wr_ovf), .rprst(rprst),
    .tx_cr_read(tx_cr_read), .tx_d_read(tx_d_read), .tx_rdy(tx_rdy),
    .ph_cr(ph_cr), .pd_cr(pd_cr), .nph_cr(nph_cr), .npd_cr(npd_cr),
    .credit_available(credit_available), .tx_empty(tx_empty), .tx_val(tx_val),
    .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data)
  );

  always #4 clk_125 = ~clk_125;

  int n_chk = 0;
  int n_err = 0;
  int n_words, n_ends, n_sts;

  // Reference model: stored words/credits as arrays with fill counts and read indices.
  logic [65:0] m_d [DD];
  logic [11:0] m_c [CD];
  int          m_nw, m_rd, m_nc, m_crd;
  bit          m_val, m_st, m_end, m_ovf, m_pend, m_cav;
  logic [63:0] m_data;
  int          m_ntype, m_ndata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit fits(int t, int d);
    if (t == 0) return (ph_cr >= 1) && (int'(pd_cr) >= d);
    if (t == 1) return (nph_cr >= 1) && (int'(npd_cr) >= d);
    return 1'b1;
  endfunction

  task automatic model();
    bit pop, f;
    int old_nc;
    f = fits(m_ntype, m_ndata);
    old_nc = m_nc;
    if (rst) begin
      m_nw = 0; m_rd = 0; m_nc = 0; m_crd = 0;
      m_ovf = 0; m_pend = 0; m_cav = 0; m_val = 0; m_st = 0; m_end = 0; m_data = '0;
      m_ntype = 0; m_ndata = 0;
    end else if (wr_clr) begin
      m_nw = 0; m_rd = 0; m_nc = 0; m_crd = 0;
      m_ovf = 0; m_pend = 0; m_cav = 0; m_val = 0;
    end else begin
      pop = tx_d_read && tx_rdy && (m_rd != m_nw) && !rprst;
      if (wr_en) begin
        if (m_nw < DD) begin m_d[m_nw] = {wr_sop, wr_eop, wr_data}; m_nw++; end
        else m_ovf = 1;
        if (wr_eop) begin
          if (m_nc < CD) begin m_c[m_nc] = wr_cr; m_nc++; end
          else m_ovf = 1;
        end
      end
      if (rprst) begin
        m_rd = 0; m_crd = 0; m_pend = 0; m_cav = 0; m_val = 0;
      end else begin
        m_val = pop;
        if (m_pend) m_cav = f;
        if (pop) begin
          m_st = m_d[m_rd][65]; m_end = m_d[m_rd][64]; m_data = m_d[m_rd][63:0];
          m_rd++;
          if (m_st) begin m_pend = 0; m_cav = 0; end
        end
        if (tx_cr_read) begin
          if (m_crd < old_nc) begin
            m_ntype = int'(m_c[m_crd][11:10]); m_ndata = int'(m_c[m_crd][9:0]); m_crd++;
          end else begin
            m_ntype = 3; m_ndata = 0;
          end
          m_pend = 1; m_cav = 0;
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare #1 later, then drop one-shot strobes.
  task automatic step();
    @(posedge clk_125);
    model();
    #1;
    chk("tx_val", tx_val, m_val);
    chk("tx_data", tx_data, m_data);
    chk("tx_st", tx_st, m_st);
    chk("tx_end", tx_end, m_end);
    chk("tx_empty", tx_empty, m_rd == m_nw);
    chk("credit_available", credit_available, m_cav);
    chk("wr_ovf", wr_ovf, m_ovf);
    if (tx_val) begin
      n_words++;
      if (tx_end) n_ends++;
      if (tx_st) n_sts++;
    end
    rst = 0; wr_clr = 0; wr_en = 0; wr_sop = 0; wr_eop = 0; rprst = 0; tx_cr_read = 0;
  endtask

  task automatic put(input bit s, input bit e, input logic [11:0] cr);
    wr_en = 1; wr_sop = s; wr_eop = e; wr_cr = cr;
    wr_data = {$urandom, $urandom};
    step();
  endtask

  task automatic load_std();
    put(1, 0, 12'h0); put(0, 0, 12'h0); put(0, 1, {2'd0, 10'd2});
    put(1, 0, 12'h0); put(0, 1, {2'd1, 10'd0});
  endtask

  task automatic clr_counts();
    n_words = 0; n_ends = 0; n_sts = 0;
  endtask

  initial begin
    rst = 1; wr_clr = 0; wr_en = 0; wr_sop = 0; wr_eop = 0; wr_data = '0; wr_cr = '0;
    rprst = 0; tx_cr_read = 0; tx_d_read = 0; tx_rdy = 0;
    ph_cr = 8'd4; pd_cr = 12'd8; nph_cr = 8'd1; npd_cr = 12'd0;
    clr_counts();
    step();
    chk("reset_empty", tx_empty, 1'b1);
    step();

    // Basic load, lookup, full read.
    load_std();
    tx_cr_read = 1; step();
    step();
    chk("cav_at_2", credit_available, 1'b1);
    clr_counts();
    tx_d_read = 1; tx_rdy = 1;
    for (int i = 0; i < 7; i++) step();
    chk("words_read", n_words, 5);
    chk("ends_read", n_ends, 2);
    chk("sts_read", n_sts, 2);
    chk("empty_after", tx_empty, 1'b1);
    tx_d_read = 0;

    // Credit shortfall, then relief.
    wr_clr = 1; step();
    load_std();
    pd_cr = 12'd1;
    tx_cr_read = 1; step();
    for (int i = 0; i < 4; i++) step();
    chk("cav_short", credit_available, 1'b0);
    pd_cr = 12'd2; step();
    chk("cav_relief", credit_available, 1'b1);

    // Drain, rewind, replay.
    tx_d_read = 1;
    for (int i = 0; i < 7; i++) step();
    tx_d_read = 0;
    rprst = 1; step();
    chk("rewind_not_empty", tx_empty, 1'b0);
    tx_cr_read = 1; step();
    clr_counts();
    tx_d_read = 1;
    for (int i = 0; i < 7; i++) step();
    chk("replay_words", n_words, 5);
    chk("replay_ends", n_ends, 2);

    // tx_rdy toggling.
    rprst = 1; step();
    clr_counts();
    for (int i = 0; i < 12; i++) begin tx_rdy = (i % 2 == 0); step(); end
    chk("toggle_words", n_words, 5);
    tx_rdy = 1; tx_d_read = 0;

    // Data store overflow.
    wr_clr = 1; step();
    for (int i = 0; i <= DD; i++) put(i == 0, i == DD, {2'd2, 10'd0});
    chk("ovf_set", wr_ovf, 1'b1);
    clr_counts();
    tx_d_read = 1;
    for (int i = 0; i < DD + 3; i++) step();
    chk("ovf_words", n_words, DD);
    chk("ovf_no_end", n_ends, 0);
    tx_d_read = 0;
    wr_clr = 1; step();
    chk("clr_ovf", wr_ovf, 1'b0);
    chk("clr_empty", tx_empty, 1'b1);

    // Rewind mid-TLP, then reset mid-read.
    load_std();
    tx_d_read = 1; step(); step();
    rprst = 1; step();
    chk("rprst_val", tx_val, 1'b0);
    step(); step();
    rst = 1; step();
    chk("rst_val", tx_val, 1'b0);
    chk("rst_empty", tx_empty, 1'b1);
    chk("rst_data", tx_data, 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_sop     = $urandom_range(0, 1);
      wr_eop     = ($urandom_range(0, 3) == 0);
      wr_cr      = 12'($urandom);
      wr_data    = {$urandom, $urandom};
      tx_d_read  = $urandom_range(0, 1);
      tx_rdy     = ($urandom_range(0, 3) != 0);
      tx_cr_read = ($urandom_range(0, 9) == 0);
      rprst      = ($urandom_range(0, 79) == 0);
      wr_clr     = ($urandom_range(0, 299) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      ph_cr      = 8'($urandom_range(0, 2));
      nph_cr     = 8'($urandom_range(0, 2));
      pd_cr      = 12'($urandom_range(0, 1100));
      npd_cr     = 12'($urandom_range(0, 1100));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sfif_tx_buf.md
Name: sfif_tx_buf

Overview:
- TLP store-and-replay buffer between the host loader and the PCIe core TX port.
- Downstream of the TX sequencing controller.
  - Serves that controller's credit-lookup (tx_cr_read) and data-read (tx_d_read) strobes.
  - Returns tx_val/tx_end/tx_empty/credit_available to it.
  - Honours rprst by rewinding to the first stored TLP without discarding contents.
- Loader-written TLPs are retained, so the same sequence replays any number of times.

Parameters:
AW, 9, data store address width; depth 2**AW 64-bit words
CAW, 5, credit store address width; depth 2**CAW TLP entries

Ports:
clk_125  in  1  clock
rst  in  1  synchronous active-high reset
wr_clr  in  1  flush: zero all pointers, clear wr_ovf
wr_en  in  1  write one data word
wr_data  in  64  TLP data word
wr_sop  in  1  first word of TLP
wr_eop  in  1  last word of TLP; also writes credit entry
wr_cr  in  12  credit need at wr_eop: [11:10] type (0 posted, 1 non-posted, 2 completion, 3 none), [9:0] data credits
wr_ovf  out  1  sticky: a word or credit entry was dropped
rprst  in  1  rewind read pointers (replay)
tx_cr_read  in  1  look up next TLP credit need
tx_d_read  in  1  data read gate
tx_rdy  in  1  core ready
ph_cr  in  8  posted header credits available
pd_cr  in  12  posted data credits available
nph_cr  in  8  non-posted header credits available
npd_cr  in  12  non-posted data credits available
credit_available  out  1  pending TLP fits current credits
tx_empty  out  1  no unread words remain
tx_val  out  1  tx_data valid
tx_st  out  1  tx_data is TLP start
tx_end  out  1  tx_data is TLP end
tx_data  out  64  TLP word to core

Behaviour:
- Reset (rst high at clock edge):
  - all pointers 0; pending 0.
  - wr_ovf, credit_available, tx_val, tx_st, tx_end = 0; tx_data = 0; tx_empty = 1.
  - Stored contents are don't-care.
- Pointers are AW+1 / CAW+1 bits; no wrap-around.
  - Data store full when wr_ptr == 2**AW; credit store full when cwr_ptr == 2**CAW.
  - Full stores hold until wr_clr or rst.
- Write:
  - wr_en with data store not full: stores {sop,eop,data} at wr_ptr, wr_ptr+1.
  - wr_en with data store full: word dropped, wr_ovf <= 1.
  - wr_en & wr_eop with credit store not full: stores wr_cr at cwr_ptr, cwr_ptr+1.
  - wr_en & wr_eop with credit store full: entry dropped, wr_ovf <= 1.
  - Writes are allowed while reading; new words become readable the next cycle.
- tx_empty = (rd_ptr == wr_ptr), combinational from registered pointers.
- Read: pop = tx_d_read & tx_rdy & ~tx_empty.
  - On pop: tx_data/tx_st/tx_end <= stored word/flags at rd_ptr, tx_val <= 1, rd_ptr+1.
  - Otherwise tx_val <= 0, and tx_data/tx_st/tx_end hold their values.
  - Latency: 1 cycle from pop to tx_val.
  - When the last stored word is popped, tx_empty = 1 in the same cycle tx_val/tx_end present it.
- Credit lookup:
  - On tx_cr_read: latch entry at crd_ptr into need, pending <= 1, credit_available <= 0, crd_ptr+1.
  - If crd_ptr == cwr_ptr on tx_cr_read: need = type 3 (none), which always fits.
  - While pending, each cycle: credit_available <= fit.
    - type 0: ph_cr >= 1 and pd_cr >= data.
    - type 1: nph_cr >= 1 and npd_cr >= data.
    - type 2/3: always 1.
    - Comparisons are unsigned.
  - Earliest credit_available is 2 cycles after tx_cr_read.
  - First pop with the popped word's sop set: pending <= 0, credit_available <= 0 in the same cycle.
- rprst high:
  - rd_ptr <= 0, crd_ptr <= 0, pending <= 0, credit_available <= 0, tx_val <= 0.
  - Write side unaffected.
- Simultaneous events:
  - rprst overrides pop and tx_cr_read in the same cycle.
  - wr_clr overrides everything except rst.
  - wr_clr resets write and read pointers; store contents are not cleared.
- Reset or rprst mid-packet: the partial TLP is abandoned; no tx_end is generated for it.

Test Plan:
- Load 2 TLPs (3 words, type 0 data 2; 2 words, type 1 data 0); ph_cr=4, pd_cr=8, nph_cr=1, npd_cr=0; tx_cr_read -> credit_available=1 at +2; hold tx_d_read & tx_rdy -> 5 words on tx_val, tx_st on words 1 and 4, tx_end on words 3 and 5, tx_empty=1 with word 5.
- Same load, pd_cr=1 -> credit_available stays 0; raise pd_cr to 2 -> credit_available=1 the next cycle.
- Drain, then pulse rprst -> tx_empty=0, crd_ptr=0; repeat lookup and read -> identical 5-word stream.
- tx_rdy toggled 1/0 during read -> tx_val only the cycle after each tx_rdy=1; word order preserved, no duplicates or skips.
- Write 2**AW+1 words -> wr_ovf=1; extra word absent from the read stream; wr_clr -> wr_ovf=0, tx_empty=1.
- rprst asserted mid-TLP (after word 2) and rst mid-read -> outputs return to the rewind/reset values above on the next cycle; replay starts from word 1.
